// File: rtl/sram_pkg.sv
// Shared types and default timing for the SRAM access controller.
package sram_pkg;

  localparam int unsigned DEF_COLS    = 16;
  localparam int unsigned DEF_ROWS    = 16;
  localparam int unsigned DEF_PRE_CYC = 2;
  localparam int unsigned DEF_WL_CYC  = 2;
  localparam int unsigned DEF_SA_CYC  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    WL    = 2'd2,
    SENSE = 2'd3
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_wl_decoder.sv
// Registered one-hot wordline decoder; rows at or above ROWS never fire.
module sram_wl_decoder
  import sram_pkg::*;
#(
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned ADDR_W = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [ROWS-1:0]   wl_o
);

  logic [ROWS-1:0] wl_d, wl_q;

  always_comb begin
    wl_d = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      wl_d[r] = en_i && (addr_i == ADDR_W'(r));
    end
  end

  // Async clear drops the wordline the moment reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wl_q <= '0;
    else        wl_q <= wl_d;
  end

  assign wl_o = wl_q;

endmodule

// File: rtl/sram_access_ctrl.sv
// Sequences precharge, wordline, write drive and sense for one SRAM macro access.
module sram_access_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned COLS    = DEF_COLS,
  parameter int unsigned ROWS    = DEF_ROWS,
  parameter int unsigned ADDR_W  = $clog2(ROWS),
  parameter int unsigned PRE_CYC = DEF_PRE_CYC,
  parameter int unsigned WL_CYC  = DEF_WL_CYC,
  parameter int unsigned SA_CYC  = DEF_SA_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [COLS-1:0]   wdata_i,
  output logic              ready_o,
  output logic              rd_wr_o,
  output logic              pre_en_o,
  output logic [ROWS-1:0]   wl_o,
  output logic [COLS-1:0]   bl_wr_o,
  output logic [COLS-1:0]   blb_wr_o,
  output logic              sae_o,
  input  logic [COLS-1:0]   sa_data_i,
  output logic [COLS-1:0]   rdata_o,
  output logic              rvalid_o,
  output logic              wdone_o,
  output logic              err_o
);

  localparam int unsigned MAX_CYC = max3(PRE_CYC, WL_CYC, SA_CYC);
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [COLS-1:0]   wdata_q, wdata_d;
  logic [COLS-1:0]   rdata_q, rdata_d;
  logic              ready_q, ready_d, rd_wr_q, rd_wr_d, pre_en_q, pre_en_d, sae_q, sae_d;
  logic              rvalid_q, rvalid_d, wdone_q, wdone_d, err_q, err_d;
  logic [COLS-1:0]   bl_wr_q, bl_wr_d, blb_wr_q, blb_wr_d;
  logic              accept, addr_ok, wr_win, wl_en;

  // Next state plus outputs derived from it, so registered outputs align with the state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    accept   = req_i && ready_q;
    addr_ok  = {1'b0, addr_i} < (ADDR_W + 1)'(ROWS);

    if (accept) begin
      we_d    = we_i;
      addr_d  = addr_i;
      wdata_d = wdata_i;
    end

    case (state_q)
      IDLE: begin
        if (accept && addr_ok) begin
          state_d = PRE;
          cnt_d   = CNT_W'(PRE_CYC - 1);
        end
      end
      PRE: begin
        if (cnt_q == '0) begin
          state_d = WL;
          cnt_d   = CNT_W'(WL_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WL: begin
        if (cnt_q == '0) begin
          state_d = we_q ? IDLE : SENSE;
          cnt_d   = we_q ? '0 : CNT_W'(SA_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SENSE: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          rdata_d = sa_data_i;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    wl_en    = (state_d == WL);
    wr_win   = wl_en && we_q;
    ready_d  = (state_d == IDLE);
    pre_en_d = (state_d == IDLE) || (state_d == PRE);
    sae_d    = (state_d == SENSE);
    rd_wr_d  = !wr_win;
    bl_wr_d  = wr_win ? wdata_q : '1;
    blb_wr_d = wr_win ? ~wdata_q : '1;
    rvalid_d = (state_q == SENSE) && (state_d == IDLE);
    wdone_d  = (state_q == WL) && (state_d == IDLE);
    err_d    = accept && !addr_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b1;
      rd_wr_q  <= 1'b1;
      pre_en_q <= 1'b1;
      sae_q    <= 1'b0;
      bl_wr_q  <= '1;
      blb_wr_q <= '1;
      rvalid_q <= 1'b0;
      wdone_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      rd_wr_q  <= rd_wr_d;
      pre_en_q <= pre_en_d;
      sae_q    <= sae_d;
      bl_wr_q  <= bl_wr_d;
      blb_wr_q <= blb_wr_d;
      rvalid_q <= rvalid_d;
      wdone_q  <= wdone_d;
      err_q    <= err_d;
    end
  end

  sram_wl_decoder #(
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_wl_dec (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (wl_en),
    .addr_i (addr_q),
    .wl_o   (wl_o)
  );

  assign ready_o  = ready_q;
  assign rd_wr_o  = rd_wr_q;
  assign pre_en_o = pre_en_q;
  assign sae_o    = sae_q;
  assign bl_wr_o  = bl_wr_q;
  assign blb_wr_o = blb_wr_q;
  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  assign wdone_o  = wdone_q;
  assign err_o    = err_q;

endmodule
